led_pwm_bank: RTL and testbench

LED_PWM_BANK -- requirements
Module: led_pwm_bank

---
 rtl/led_pwm_bank.sv | 130 +++++++++++++
 tb/tb_led_pwm_bank.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: a bank of independent LED drivers sharing one free-running
// counter. Each channel can be off, on, blinking at a selectable rate, or
// "breathing" (PWM duty ramping up and down). led_o is registered.
//
// Config handshake: we_i is a single-cycle strobe with no ready/backpressure;
// the write lands on the rising edge where we_i=1 and ch_i addresses an
// existing channel. Writes to non-existent channels are dropped silently.
module led_pwm_bank #(
  parameter int CHANNELS   = 4,
  parameter int BITS       = 26,
  parameter int PWM_BITS   = 8,
  parameter int RESET_MODE = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rstn_i,
  input  logic                                          we_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_i,
  input  logic [1:0]                                    mode_i,
  input  logic [4:0]                                    rate_i,
  output logic [CHANNELS-1:0]                           led_o
);

  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW       = $clog2(BITS);
  // Smallest tap that still leaves room for a full PWM period per step.
  localparam int MIN_TAP  = 2 * PWM_BITS - 1;
  // Largest rate that maps to a tap at or above MIN_TAP.
  localparam int MAX_RATE = BITS - 2 * PWM_BITS;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;
  localparam logic [1:0] RST_MODE     = 2'(RESET_MODE);

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = '0;

  logic [BITS-1:0]     cnt_q, cnt_d;
  logic [1:0]          mode_q [CHANNELS];
  logic [1:0]          mode_d [CHANNELS];
  logic [4:0]          rate_q [CHANNELS];
  logic [4:0]          rate_d [CHANNELS];
  logic [PWM_BITS-1:0] duty_q [CHANNELS];
  logic [PWM_BITS-1:0] duty_d [CHANNELS];
  logic [CHANNELS-1:0] dir_q, dir_d;
  logic [CHANNELS-1:0] led_q, led_d;

  logic [TW-1:0]       tap_c  [CHANNELS];
  logic [BITS-1:0]     mask_c [CHANNELS];
  logic [CHANNELS-1:0] step_c;

  // Map a rate to a counter tap, clamping before subtraction so a large rate
  // never underflows into a bogus high tap.
  function automatic logic [TW-1:0] tap_of(input logic [4:0] r);
    int ri;
    ri = {27'd0, r};
    if (ri > MAX_RATE) return TW'(MIN_TAP);
    else               return TW'(BITS - 1 - ri);
  endfunction

  // Next-state for the shared counter and every channel's config, duty and LED.
  always_comb begin
    cnt_d = cnt_q + BITS'(1);
    dir_d = dir_q;
    led_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mode_d[k] = mode_q[k];
      rate_d[k] = rate_q[k];
      duty_d[k] = duty_q[k];
      tap_c[k]  = tap_of(rate_q[k]);
      // Step fires when the low (tap-PWM_BITS+1) counter bits are all ones,
      // which is always the last cycle of a PWM period.
      mask_c[k] = (BITS'(1) << (tap_c[k] - PWM_BITS + 1)) - BITS'(1);
      step_c[k] = ((cnt_q & mask_c[k]) == mask_c[k]);

      case (mode_q[k])
        MODE_OFF:   led_d[k] = 1'b0;
        MODE_ON:    led_d[k] = 1'b1;
        MODE_BLINK: led_d[k] = cnt_q[tap_c[k]];
        default:    led_d[k] = (cnt_q[PWM_BITS-1:0] < duty_q[k]);
      endcase

      // Breathe ramp: turn around at the ends, never wrap.
      if (mode_q[k] == MODE_BREATHE && step_c[k]) begin
        if (!dir_q[k]) begin
          if (duty_q[k] != DUTY_MAX) duty_d[k] = duty_q[k] + 1'b1;
          if (duty_d[k] == DUTY_MAX) dir_d[k] = 1'b1;
        end else begin
          if (duty_q[k] != DUTY_ZERO) duty_d[k] = duty_q[k] - 1'b1;
          if (duty_d[k] == DUTY_ZERO) dir_d[k] = 1'b0;
        end
      end

      // A config write restarts the ramp and overrides any same-cycle step.
      if (we_i && ({{(32-CH_W){1'b0}}, ch_i} == k)) begin
        mode_d[k] = mode_i;
        rate_d[k] = rate_i;
        duty_d[k] = DUTY_ZERO;
        dir_d[k]  = 1'b0;
      end
    end
  end

  // State registers; synchronous active-low reset overrides any write.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      dir_q <= '0;
      led_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        mode_q[k] <= RST_MODE;
        rate_q[k] <= 5'd0;
        duty_q[k] <= DUTY_ZERO;
      end
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      led_q <= led_d;
      for (int k = 0; k < CHANNELS; k++) begin
        mode_q[k] <= mode_d[k];
        rate_q[k] <= rate_d[k];
        duty_q[k] <= duty_d[k];
      end
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank (BITS=10, PWM_BITS=4, CHANNELS=4,
// RESET_MODE=2), plus a 3-channel instance for out-of-range channel writes.
module tb_led_pwm_bank;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rstn;
  logic       we;
  logic [1:0] ch;
  logic [1:0] mode;
  logic [4:0] rate;
  logic [3:0] led;
  logic       we_s;
  logic [1:0] ch_s;
  logic [2:0] led_s;

  always #5 clk = ~clk;

  led_pwm_bank #(.CHANNELS(4), .BITS(10), .PWM_BITS(4), .RESET_MODE(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .we_i(we), .ch_i(ch),
    .mode_i(mode), .rate_i(rate), .led_o(led)
  );

  led_pwm_bank #(.CHANNELS(3), .BITS(10), .PWM_BITS(4), .RESET_MODE(1)) dut_s (
    .clk_i(clk), .rstn_i(rstn), .we_i(we_s), .ch_i(ch_s),
    .mode_i(mode), .rate_i(rate), .led_o(led_s)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int ecnt   = 0;   // rising edges since reset release

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arm a write on the big instance; it lands at the next edge.
  task automatic wr(input logic [1:0] c, input logic [1:0] m, input logic [4:0] r);
    we = 1'b1; ch = c; mode = m; rate = r;
    tick();
    we = 1'b0;
  endtask

  int hi;
  int exp_duty;

  initial begin
    rstn = 1'b0; we = 1'b0; ch = '0; mode = '0; rate = '0;
    we_s = 1'b0; ch_s = '0;

    // Reset state
    repeat (3) tick();
    check("reset_led", {28'd0, led}, 32'h0);
    check("reset_led_s", {29'd0, led_s}, 32'h0);

    rstn = 1'b1;
    ecnt = 0;

    // Free-run blink, tap 9: low for cnt 0..511, high 512..1023
    tick();
    check("blink_e1", {28'd0, led}, 32'h0);
    check("small_on_e1", {29'd0, led_s}, 32'h7);
    run_to(512);  check("blink_e512", {28'd0, led}, 32'h0);
    run_to(513);  check("blink_e513", {28'd0, led}, 32'hF);
    run_to(1024); check("blink_e1024", {28'd0, led}, 32'hF);
    run_to(1025); check("blink_e1025", {28'd0, led}, 32'h0);

    // ch1 blink rate 2 -> tap 7, written at edge 1026
    wr(2'd1, 2'd2, 5'd2);
    run_to(1152); check("rate2_c127", {28'd0, led}, 32'h0);
    run_to(1153); check("rate2_c128", {28'd0, led}, 32'h2);
    run_to(1280); check("rate2_c255", {28'd0, led}, 32'h2);
    run_to(1281); check("rate2_c256", {28'd0, led}, 32'h0);

    // ch1 rate 31 clamps to tap 7, written at edge 1282
    wr(2'd1, 2'd2, 5'd31);
    run_to(1408); check("rate31_c383", {28'd0, led}, 32'h0);
    run_to(1409); check("rate31_c384", {28'd0, led}, 32'h2);

    // ch2 breathe rate 2 (step every 16), written at edge 1424
    run_to(1423);
    wr(2'd2, 2'd3, 5'd2);
    for (int j = 0; j < 46; j++) begin
      exp_duty = (j <= 15) ? j : ((j <= 30) ? 30 - j : j - 30);
      hi = 0;
      repeat (16) begin
        tick();
        hi += int'(led[2]);
      end
      check($sformatf("breathe_win%0d", j), 32'(hi), 32'(exp_duty));
    end

    // Write on a step-event edge while descending: write wins, ramp restarts up
    run_to(2175);
    wr(2'd2, 2'd3, 5'd2);
    for (int j = 0; j < 3; j++) begin
      hi = 0;
      repeat (16) begin
        tick();
        hi += int'(led[2]);
      end
      check($sformatf("step_write_win%0d", j), 32'(hi), 32'(j));
    end

    // ch3 on, then off
    wr(2'd3, 2'd1, 5'd0);
    check("ch3_on_e0", {31'd0, led[3]}, 32'h0);
    tick();
    check("ch3_on_e1", {31'd0, led[3]}, 32'h1);
    wr(2'd3, 2'd0, 5'd0);
    check("ch3_off_e0", {31'd0, led[3]}, 32'h1);
    tick();
    check("ch3_off_e1", {31'd0, led[3]}, 32'h0);

    // Out-of-range channel on the 3-channel instance is ignored
    we_s = 1'b1; ch_s = 2'd3; mode = 2'd0;
    tick();
    we_s = 1'b0;
    tick();
    check("small_bad_ch", {29'd0, led_s}, 32'h7);
    we_s = 1'b1; ch_s = 2'd2; mode = 2'd0;
    tick();
    we_s = 1'b0;
    tick();
    check("small_ch2_off", {29'd0, led_s}, 32'h3);
    check("independence", {28'd0, led}, 32'h2);

    // Reset mid-breathe with concurrent writes: reset wins
    rstn = 1'b0;
    we = 1'b1; ch = 2'd2; mode = 2'd1; rate = 5'd5;
    we_s = 1'b1; ch_s = 2'd0;
    tick();
    check("midreset_led", {28'd0, led}, 32'h0);
    check("midreset_led_s", {29'd0, led_s}, 32'h0);
    rstn = 1'b1; we = 1'b0; we_s = 1'b0;
    ecnt = 0;
    tick();
    check("post_reset_e1", {28'd0, led}, 32'h0);
    check("post_reset_s_e1", {29'd0, led_s}, 32'h7);
    run_to(129);  check("post_reset_c128", {28'd0, led}, 32'h0);
    run_to(512);  check("post_reset_e512", {28'd0, led}, 32'h0);
    run_to(513);  check("post_reset_e513", {28'd0, led}, 32'hF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
